vload_writeback: RTL and testbench
==================================

Name: vload_writeback

Overview:
- Downstream consumer of the vector load data stream (dstream beats: data, start_flag, end_flag, valid) produced by the load AXI wrapper.
- Matches each burst against a queued load command (destination vreg, byte length, track id) and writes beats into the vector register file.
- Generates row addresses and byte enables, trims the partial last beat, and reports per-command completion.
- The input stream has no backpressure, so every valid beat is consumed in the cycle it arrives.

Parameters:
- DATA_WIDTH, 64, stream/VRF row width in bits; DW_B = DATA_WIDTH/8.
- VREG_W, 5, vector register index width.
- ROW_W, 3, row-index width per vector register (rows per vreg = 2^ROW_W).
- LEN_W, 16, command byte-length width.
- ID_W, TRACK_ID_WIDTH, track id width.
- CMD_DEPTH, 2, command queue depth (power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  load command offered.
- cmd_ready  out  1  queue not full.
- cmd_vd  in  VREG_W  destination base vreg.
- cmd_len  in  LEN_W  total bytes to write (1..(2^ROW_W)*DW_B*8).
- cmd_id  in  ID_W  track id.
- in_valid  in  1  stream beat valid.
- in_start  in  1  first beat of burst.
- in_end  in  1  last beat of burst.
- in_data  in  DATA_WIDTH  beat data.
- wr_en  out  1  VRF write strobe.
- wr_addr  out  VREG_W+ROW_W  VRF row address.
- wr_data  out  DATA_WIDTH  write data.
- wr_be  out  DW_B  byte enables.
- done_valid  out  1  one-cycle completion pulse.
- done_id  out  ID_W  id of the completed command.
- done_err  out  1  completion had a length mismatch.
- err_no_cmd  out  1  sticky: a beat arrived with no matching command.
- perf_beats  out  32  beats written (see Optional Feature).
- perf_cmds  out  32  commands completed (see Optional Feature).

Behaviour:
- Reset: all outputs 0, except cmd_ready = 1. The queue empties, the FSM goes to IDLE, sticky flags clear. Reset mid-burst discards the active command; leftover beats without start then set err_no_cmd.
- Handshake: a command is accepted when cmd_valid & cmd_ready. cmd_ready = (count != CMD_DEPTH) and does not look ahead at a same-cycle pop. A push and pop in the same cycle leave the count unchanged.
- FSM states: IDLE, ACTIVE.
- IDLE, start beat, queue non-empty: pop the head into the active registers (base = vd<<ROW_W, remaining = len, id). Write beat 0. Go to ACTIVE, or finish immediately if in_end.
- IDLE, beat with empty queue or without start: drop the beat, set err_no_cmd.
- ACTIVE, beat without start: write row base+beat_cnt.
  - wr_be bit b = (beat_cnt*DW_B + b < len).
  - Beats past len are suppressed (wr_en = 0).
- ACTIVE, in_end: complete the command and return to IDLE.
- ACTIVE, start beat (protocol error): complete the current command with done_err = 1 in this cycle. Process the beat as an IDLE start beat using the next queue head, in the same cycle.
- done_err = 1 if an end beat arrives while bytes remain, or if any beat was suppressed for exceeding len.
- Latency: write port and done outputs are registered, 1 cycle after the input beat. done_valid coincides with the final wr_en.
- Arithmetic: wr_addr = base + beat_cnt, modulo 2^(VREG_W+ROW_W). The wrap from vreg 31 to vreg 0 is silent. beat_cnt saturates at its maximum.
- Back-to-back bursts: an end beat followed by a start beat in the next cycle is accepted with no bubble.

Optional Feature:
- Macro: VLOAD_WB_PERF_EN.
- Defined: perf_beats increments on each wr_en; perf_cmds increments on each done_valid. Both wrap at 2^32 and clear on rst.
- Undefined: no counter logic is built; perf_beats and perf_cmds are tied to 0. The ports exist in both builds.

Decomposition:
- Shared package (rvvLitePkg): vload_wb_cmd_t {id, vd, len}; DW_B; VRF_ADDR_W = VREG_W+ROW_W.
- Command queue: reuse cva5_fifo with DATA_WIDTH = $bits(vload_wb_cmd_t).
- One sub-module: vload_wb_be_gen, combinational. Inputs: beat_cnt, len. Outputs: byte enables and a last-needed-beat flag.

Test Plan (DATA_WIDTH=64, ROW_W=3):
- cmd vd=3 len=20 id=5; beats S,-,E on consecutive cycles -> wr_addr 24,25,26; wr_be FF,FF,0F; done_valid with id=5, err=0 on the third write.
- cmd len=8; single beat with start and end -> one write with be FF; done same cycle; FSM returns to IDLE.
- Start beat with empty queue -> no wr_en, err_no_cmd=1 and stays 1 until rst.
- cmd len=24; end on the 2nd beat -> two writes (FF,FF), then done_err=1.
- Two cmds (vd=1 id=1, vd=2 id=2) queued; gapless bursts of 2 beats each -> addrs 8,9,16,17; done ids 1 then 2; cmd_ready drops while the queue holds 2.
- rst asserted after the 1st of 3 beats -> outputs zero next cycle; the 2 remaining beats set err_no_cmd; no done_valid.

Source files
------------

// File: rtl/vload_writeback_pkg.sv
// Shared types and sizing for the vector-load writeback slice.
package vload_writeback_pkg;
   localparam int DATA_WIDTH     = 64;
   localparam int VREG_W         = 5;
   localparam int ROW_W          = 3;
   localparam int LEN_W          = 16;
   localparam int TRACK_ID_WIDTH = 4;
   localparam int ID_W           = TRACK_ID_WIDTH;
   localparam int CMD_DEPTH      = 2;
   localparam int DW_B           = DATA_WIDTH / 8;
   localparam int VRF_ADDR_W     = VREG_W + ROW_W;
   // One spare bit over the longest legal burst (8 vregs of rows) so overruns stay visible.
   localparam int BCNT_W         = ROW_W + 4;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [VREG_W-1:0] vd;
      logic [LEN_W-1:0]  len;
   } vload_wb_cmd_t;

   typedef enum logic {IDLE, ACTIVE} vload_wb_state_e;

   function automatic logic [BCNT_W-1:0] sat_inc(input logic [BCNT_W-1:0] v);
      return (&v) ? v : v + BCNT_W'(1);
   endfunction
endpackage

// File: rtl/vload_writeback_if.sv
// Command, load-stream and VRF-write/completion bundle around vload_writeback.
interface vload_writeback_if;
   import vload_writeback_pkg::*;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [VREG_W-1:0]     cmd_vd;
   logic [LEN_W-1:0]      cmd_len;
   logic [ID_W-1:0]       cmd_id;
   logic                  in_valid;
   logic                  in_start;
   logic                  in_end;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  wr_en;
   logic [VRF_ADDR_W-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DW_B-1:0]       wr_be;
   logic                  done_valid;
   logic [ID_W-1:0]       done_id;
   logic                  done_err;

   modport master (
      output cmd_valid, cmd_vd, cmd_len, cmd_id, in_valid, in_start, in_end, in_data,
      input  cmd_ready, wr_en, wr_addr, wr_data, wr_be, done_valid, done_id, done_err
   );
   modport slave (
      input  cmd_valid, cmd_vd, cmd_len, cmd_id, in_valid, in_start, in_end, in_data,
      output cmd_ready, wr_en, wr_addr, wr_data, wr_be, done_valid, done_id, done_err
   );
endinterface

// File: rtl/cva5_fifo.sv
// Small circular FIFO; push is ignored when full, pop is ignored when empty.
module cva5_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid,
   output logic                  full
);
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]         wptr_q, rptr_q;
   logic [PW:0]           cnt_q;
   logic                  do_push, do_pop;

   assign valid    = (cnt_q != '0);
   assign full     = (cnt_q == (PW+1)'(FIFO_DEPTH));
   assign do_push  = push & ~full;
   assign do_pop   = pop & valid;
   assign data_out = mem_q[rptr_q];

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + PW'(1);
         if (do_pop)  rptr_q <= rptr_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule

// File: rtl/vload_writeback_be_gen.sv
// Byte enables for one beat of a command, plus whether this beat holds the final needed byte.
module vload_wb_be_gen
   import vload_writeback_pkg::*;
(
   input  logic [BCNT_W-1:0] beat_cnt_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic [DW_B-1:0]   be_o,
   output logic              last_o
);
   localparam int SH = $clog2(DW_B);

   logic [31:0] off;
   assign off = 32'(beat_cnt_i) << SH;

   for (genvar b = 0; b < DW_B; b++) begin : g_be
      assign be_o[b] = (off + 32'(b)) < 32'(len_i);
   end

   assign last_o = (off + 32'(DW_B)) >= 32'(len_i);
endmodule

// File: rtl/vload_writeback.sv
// Matches load-stream bursts to queued commands and writes rows into the VRF.
// Optional VLOAD_WB_PERF_EN builds the beat/command performance counters.
module vload_writeback
   import vload_writeback_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   vload_writeback_if.slave   bus,
   output logic               err_no_cmd,
   output logic [31:0]        perf_beats,
   output logic [31:0]        perf_cmds
);
   vload_wb_cmd_t push_cmd, head;
   logic          q_valid, q_full, pop;

   assign push_cmd      = '{id: bus.cmd_id, vd: bus.cmd_vd, len: bus.cmd_len};
   assign bus.cmd_ready = ~q_full;

   cva5_fifo #(.DATA_WIDTH($bits(vload_wb_cmd_t)), .FIFO_DEPTH(CMD_DEPTH)) u_cmdq (
      .clk(clk), .rst(rst), .push(bus.cmd_valid & ~q_full), .pop(pop),
      .data_in(push_cmd), .data_out(head), .valid(q_valid), .full(q_full)
   );

   vload_wb_state_e       state_q;
   logic [VRF_ADDR_W-1:0] base_q;
   logic [LEN_W-1:0]      len_q;
   logic [ID_W-1:0]       id_q;
   logic [BCNT_W-1:0]     bcnt_q;
   logic                  ovf_q;
   logic                  wr_en_q, done_valid_q, done_err_q, err_no_cmd_q;
   logic [VRF_ADDR_W-1:0] wr_addr_q;
   logic [DATA_WIDTH-1:0] wr_data_q;
   logic [DW_B-1:0]       wr_be_q;
   logic [ID_W-1:0]       done_id_q;
   logic                  pend_v_q, pend_err_q;
   logic [ID_W-1:0]       pend_id_q;

   logic                  beat_c, abort, fin, fin_err, drop, hit, last, wr_go;
   logic [BCNT_W-1:0]     cur_cnt;
   logic [LEN_W-1:0]      cur_len;
   logic [VRF_ADDR_W-1:0] cur_base;
   logic [ID_W-1:0]       fin_id;
   logic [DW_B-1:0]       be;

   // A start beat always takes the next queued command, even while one is still active.
   assign pop      = bus.in_valid & bus.in_start & q_valid;
   assign beat_c   = bus.in_valid & ~bus.in_start & (state_q == ACTIVE);
   assign abort    = bus.in_valid & bus.in_start & (state_q == ACTIVE);
   assign drop     = bus.in_valid & ~pop & ~beat_c;
   assign cur_cnt  = pop ? '0 : bcnt_q;
   assign cur_len  = pop ? head.len : len_q;
   assign cur_base = pop ? {head.vd, {ROW_W{1'b0}}} : base_q;
   assign fin_id   = pop ? head.id : id_q;

   vload_wb_be_gen u_be (.beat_cnt_i(cur_cnt), .len_i(cur_len), .be_o(be), .last_o(last));

   assign hit     = be[0];
   assign wr_go   = (pop | beat_c) & hit;
   assign fin     = (pop | beat_c) & bus.in_end;
   assign fin_err = (beat_c & ovf_q) | ~hit | ~last;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         base_q       <= '0;
         len_q        <= '0;
         id_q         <= '0;
         bcnt_q       <= '0;
         ovf_q        <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         wr_be_q      <= '0;
         done_valid_q <= 1'b0;
         done_id_q    <= '0;
         done_err_q   <= 1'b0;
         err_no_cmd_q <= 1'b0;
         pend_v_q     <= 1'b0;
         pend_id_q    <= '0;
         pend_err_q   <= 1'b0;
      end else begin
         wr_en_q <= wr_go;
         if (wr_go) begin
            wr_addr_q <= cur_base + VRF_ADDR_W'(cur_cnt);
            wr_data_q <= bus.in_data;
            wr_be_q   <= be;
         end

         if (pop) begin
            base_q <= cur_base;
            len_q  <= head.len;
            id_q   <= head.id;
            bcnt_q <= BCNT_W'(1);
            ovf_q  <= 1'b0;
         end else if (beat_c) begin
            bcnt_q <= sat_inc(bcnt_q);
            ovf_q  <= ovf_q | ~hit;
         end

         if (fin || (abort && !pop)) state_q <= IDLE;
         else if (pop)               state_q <= ACTIVE;

         err_no_cmd_q <= err_no_cmd_q | drop;

         // An aborted command and a single-beat replacement can finish together;
         // the abort takes the port and the newer completion waits one cycle.
         if (pend_v_q) begin
            done_valid_q <= 1'b1;
            done_id_q    <= pend_id_q;
            done_err_q   <= pend_err_q;
         end else if (abort) begin
            done_valid_q <= 1'b1;
            done_id_q    <= id_q;
            done_err_q   <= 1'b1;
         end else begin
            done_valid_q <= fin;
            done_id_q    <= fin ? fin_id : '0;
            done_err_q   <= fin & fin_err;
         end
         pend_v_q   <= fin & (pend_v_q | abort);
         pend_id_q  <= fin_id;
         pend_err_q <= fin_err;
      end
   end

   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.wr_be      = wr_be_q;
   assign bus.done_valid = done_valid_q;
   assign bus.done_id    = done_id_q;
   assign bus.done_err   = done_err_q;
   assign err_no_cmd     = err_no_cmd_q;

`ifdef VLOAD_WB_PERF_EN
   logic [31:0] perf_beats_q, perf_cmds_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_beats_q <= '0;
         perf_cmds_q  <= '0;
      end else begin
         perf_beats_q <= perf_beats_q + 32'(wr_en_q);
         perf_cmds_q  <= perf_cmds_q + 32'(done_valid_q);
      end
   end
   assign perf_beats = perf_beats_q;
   assign perf_cmds  = perf_cmds_q;
`else
   assign perf_beats = '0;
   assign perf_cmds  = '0;
`endif
endmodule

// File: tb/tb_vload_writeback.sv
// Scoreboard bench for vload_writeback: expected writes/completions queued at drive time.
module tb_vload_writeback;
   import vload_writeback_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        err_no_cmd;
   logic [31:0] perf_beats, perf_cmds;

   vload_writeback_if bus();

   vload_writeback dut (
      .clk(clk), .rst(rst), .bus(bus),
      .err_no_cmd(err_no_cmd), .perf_beats(perf_beats), .perf_cmds(perf_cmds)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [VRF_ADDR_W-1:0] a;
      logic [DATA_WIDTH-1:0] d;
      logic [DW_B-1:0]       be;
   } wexp_t;
   typedef struct {
      logic [ID_W-1:0] id;
      logic            err;
   } dexp_t;

   wexp_t wq[$];
   dexp_t dq[$];
   wexp_t we;
   dexp_t de;
   int nvec = 0, nerr = 0, nwr = 0, ndone = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         nwr   = 0;
         ndone = 0;
      end else begin
         if (bus.wr_en) begin
            nwr++;
            if (wq.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
               we = wq.pop_front();
               chk("wr_addr", 64'(bus.wr_addr), 64'(we.a));
               chk("wr_data", bus.wr_data, we.d);
               chk("wr_be", 64'(bus.wr_be), 64'(we.be));
            end
         end
         if (bus.done_valid) begin
            ndone++;
            if (dq.size() == 0) chk("done_unexpected", 1, 0);
            else begin
               de = dq.pop_front();
               chk("done_id", 64'(bus.done_id), 64'(de.id));
               chk("done_err", 64'(bus.done_err), 64'(de.err));
            end
         end
      end
   end

   task automatic send_cmd(input int vd, input int len, input int id);
      bit ok = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_vd    = VREG_W'(vd);
      bus.cmd_len   = LEN_W'(len);
      bus.cmd_id    = ID_W'(id);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bus.cmd_ready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      if (!ok) chk("cmd_accept", 0, 1);
   endtask

   task automatic beat(input bit s, input bit e, input bit exp_wr, input int addr, input logic [DW_B-1:0] be);
      logic [DATA_WIDTH-1:0] d;
      d = {$urandom, $urandom};
      bus.in_valid = 1'b1;
      bus.in_start = s;
      bus.in_end   = e;
      bus.in_data  = d;
      if (exp_wr) wq.push_back('{a: VRF_ADDR_W'(addr), d: d, be: be});
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_start = 1'b0;
      bus.in_end   = 1'b0;
   endtask

   task automatic exp_done(input int id, input bit err);
      dq.push_back('{id: ID_W'(id), err: err});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_vd = '0; bus.cmd_len = '0; bus.cmd_id = '0;
      bus.in_valid = 1'b0; bus.in_start = 1'b0; bus.in_end = 1'b0; bus.in_data = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_cmd_ready", 64'(bus.cmd_ready), 1);
      chk("rst_wr_en", 64'(bus.wr_en), 0);
      chk("rst_done_valid", 64'(bus.done_valid), 0);
      chk("rst_err_no_cmd", 64'(err_no_cmd), 0);
      chk("rst_wr_addr", 64'(bus.wr_addr), 0);
      chk("rst_perf_beats", 64'(perf_beats), 0);
      @(posedge clk); #1;

      // three-beat burst with a trimmed tail
      send_cmd(3, 20, 5); exp_done(5, 0);
      beat(1, 0, 1, 24, 8'hFF); beat(0, 0, 1, 25, 8'hFF); beat(0, 1, 1, 26, 8'h0F);

      // single beat with start and end
      send_cmd(5, 8, 6); exp_done(6, 0);
      beat(1, 1, 1, 40, 8'hFF);

      // start beat with nothing queued
      beat(1, 1, 0, 0, 8'h00);
      @(negedge clk); chk("err_no_cmd_set", 64'(err_no_cmd), 1);
      @(posedge clk); #1;

      // end arrives with bytes still owed
      send_cmd(6, 24, 7); exp_done(7, 1);
      beat(1, 0, 1, 48, 8'hFF); beat(0, 1, 1, 49, 8'hFF);

      // beats past len are suppressed and flagged
      send_cmd(7, 8, 8); exp_done(8, 1);
      beat(1, 0, 1, 56, 8'hFF); beat(0, 0, 0, 0, 8'h00); beat(0, 1, 0, 0, 8'h00);

      // row address wraps from vreg 31 to vreg 0
      send_cmd(31, 72, 9); exp_done(9, 0);
      for (int k = 0; k < 9; k++) beat(k == 0, k == 8, 1, (248 + k) % 256, 8'hFF);

      // two queued commands, gapless bursts
      send_cmd(1, 16, 1); send_cmd(2, 16, 2);
      @(negedge clk);
      chk("cmd_ready_full", 64'(bus.cmd_ready), 0);
      chk("err_no_cmd_sticky", 64'(err_no_cmd), 1);
      @(posedge clk); #1;
      exp_done(1, 0); exp_done(2, 0);
      beat(1, 0, 1, 8, 8'hFF); beat(0, 1, 1, 9, 8'hFF);
      beat(1, 0, 1, 16, 8'hFF); beat(0, 1, 1, 17, 8'hFF);
      @(negedge clk); chk("cmd_ready_drained", 64'(bus.cmd_ready), 1);
      @(posedge clk); #1;

      // start beat mid-burst aborts the active command
      send_cmd(2, 16, 10); send_cmd(3, 8, 11);
      exp_done(10, 1); exp_done(11, 0);
      beat(1, 0, 1, 16, 8'hFF); beat(1, 1, 1, 24, 8'hFF);
      repeat (3) @(posedge clk); #1;

      // reset in the middle of a burst
      send_cmd(4, 24, 12);
      beat(1, 0, 1, 32, 8'hFF);
      @(negedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("mrst_wr_en", 64'(bus.wr_en), 0);
      chk("mrst_done_valid", 64'(bus.done_valid), 0);
      chk("mrst_err_no_cmd", 64'(err_no_cmd), 0);
      chk("mrst_cmd_ready", 64'(bus.cmd_ready), 1);
      chk("mrst_wr_addr", 64'(bus.wr_addr), 0);
      @(posedge clk); #1;
      beat(0, 0, 0, 0, 8'h00); beat(0, 1, 0, 0, 8'h00);
      @(negedge clk); chk("mrst_leftover_err", 64'(err_no_cmd), 1);
      @(posedge clk); #1;

      // normal traffic after reset
      send_cmd(0, 8, 13); exp_done(13, 0);
      beat(1, 1, 1, 0, 8'hFF);
      repeat (3) @(posedge clk); #1;

      chk("wq_drained", 64'(wq.size()), 0);
      chk("dq_drained", 64'(dq.size()), 0);
      chk("err_no_cmd_final", 64'(err_no_cmd), 1);
`ifdef VLOAD_WB_PERF_EN
      chk("perf_beats", 64'(perf_beats), 64'(nwr));
      chk("perf_cmds", 64'(perf_cmds), 64'(ndone));
`else
      chk("perf_beats", 64'(perf_beats), 0);
      chk("perf_cmds", 64'(perf_cmds), 0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
